extremum_finder_mc: RTL and testbench
=====================================

// Module: extremum_finder_mc
// PURPOSE
//  Multi-channel windowed min/max detector on the vibrometer AXI-Stream sample path.
//  Per channel, finds the signed minimum and maximum over windows of 2^EF_log_count accepted samples.
//  Each extremum is arithmetically right-shifted by EF_log_shift and emitted as one AXI-Stream beat per window.
//  Input is never stalled; the output beat is held in a register until the consumer accepts it.
// PARAMETERS
//  CHANNELS       2   number of independent channels packed in S_AXIS_tdata (ch0 = LSBs)
//  SAMPLE_WIDTH   16  signed sample width per channel
//  MAX_LOG_COUNT  24  largest legal EF_log_count; larger values are clamped to this
// PORTS
//  SYS_aclk       in   1                   single clock, rising edge
//  SYS_aresetn    in   1                   asynchronous, active-low reset
//  EF_log_count   in   5                   window length = 2^EF_log_count samples
//  EF_log_shift   in   6                   output arithmetic right shift
//  S_AXIS_tdata   in   CHANNELS*SAMPLE_WIDTH  packed signed samples
//  S_AXIS_tvalid  in   1                   sample valid
//  S_AXIS_tready  out  1                   tied to 1 (never back-pressures)
//  M_AXIS_tdata   out  CHANNELS*OUT_FIELDS*SAMPLE_WIDTH  per channel {max,min}; ch0 = LSBs
//  M_AXIS_tvalid  out  1                   result beat valid
//  M_AXIS_tready  in   1                   consumer ready
//  EF_overrun     out  1                   1-cycle pulse: an unaccepted result was overwritten
// BEHAVIOUR
//  Reset (async assert, sync release): window counter=0, M_AXIS_tvalid=0, M_AXIS_tdata=0, EF_overrun=0, trackers empty.
//  Accept = S_AXIS_tvalid (tready is always 1).
//  EF_log_count and EF_log_shift are latched on the first accept of each window; changes mid-window do not take effect until the next window.
//  First accept of a window loads max=min=sample. Later accepts: max=(s>max)?s:max and min=(s<min)?s:min, using signed compares.
//  Window completes on accept number 2^N (N = latched log_count, clamped); N=0 gives one sample per window.
//  Latency: the last sample accepted in cycle k yields M_AXIS_tvalid=1 in cycle k+1, and that sample is included in the result.
//  The next window starts on the next accept, with no dead cycle; back-to-back windows are lossless at the input.
//  Output field = extremum >>> shift, truncated to SAMPLE_WIDTH. If shift >= SAMPLE_WIDTH, the field is sign fill (0 or -1).
//  Output handshake:
//   - tvalid holds until tvalid&&tready.
//   - tdata is stable while tvalid=1 and tready=0.
//  A new result with tready=0 and tvalid=1 overwrites tdata, keeps tvalid=1, and pulses EF_overrun.
//  A new result arriving in the same cycle the old one is accepted is not an overrun; tvalid stays 1 with the new data.
//  Counter wrap: counter is MAX_LOG_COUNT+1 bits and clears on window end; it never free-runs past 2^N.
//  Reset mid-window discards the partial window; no beat is emitted for it.
// CONFIGURATION
//  EXTREMUM_FINDER_P2P_EN defined:
//   - OUT_FIELDS=3; per channel {p2p,max,min}.
//   - p2p = (max-min), computed unshifted at SAMPLE_WIDTH+1 bits unsigned, then logically shifted by EF_log_shift.
//   - p2p saturates to 2^SAMPLE_WIDTH-1.
//  EXTREMUM_FINDER_P2P_EN undefined: OUT_FIELDS=2; no subtractor is built.
// STRUCTURE
//  vibrometer_pkg holds: EF_LOG_COUNT_W=5, EF_LOG_SHIFT_W=6, and the OUT_FIELDS field-index constants (FIELD_MIN=0, FIELD_MAX=1, FIELD_P2P=2).
//  Sub-module ef_channel: one signed min/max tracker with load/update/shift; instantiated CHANNELS times in a generate loop.
//  Top level owns the window counter, config latch, output register and handshake.
// TESTING
//  1 CH=2, log_count=3, shift=1, tvalid=1.
//    ch0: -20,-10,10,20,10,-10,-30,-20 -> one beat, ch0 max=10, min=-15, at cycle after the 8th sample.
//  2 log_count=0, shift=0, samples 5,-7 on ch0 -> two beats: {5,5}, then {-7,-7}; no gap between windows.
//  3 tready=0 across two windows -> first beat held stable.
//    Second window end -> tdata replaced, EF_overrun pulses once; tready=1 -> tvalid drops next cycle.
//  4 Change log_count 3->2 after the 3rd sample -> current window still ends at 8 samples; next window ends at 4.
//  5 shift=20, SAMPLE_WIDTH=16, max=+100, min=-100 -> fields 0 and -1.
//    Assert SYS_aresetn=0 mid-window -> tvalid=0 immediately, no partial beat.
//  6 P2P_EN, ch1 samples 32767,-32768, shift=0 -> p2p saturates to 65535; shift=1 -> 32767.

Source files
------------

// File: rtl/vibrometer_pkg.sv
// Shared widths and output field layout for the vibrometer extremum finder.
// Defining EXTREMUM_FINDER_P2P_EN adds a peak-to-peak field to every channel.
package vibrometer_pkg;

    localparam int EF_LOG_COUNT_W = 5;
    localparam int EF_LOG_SHIFT_W = 6;

    localparam int FIELD_MIN = 0;
    localparam int FIELD_MAX = 1;
    localparam int FIELD_P2P = 2;

`ifdef EXTREMUM_FINDER_P2P_EN
    localparam int OUT_FIELDS = 3;
`else
    localparam int OUT_FIELDS = 2;
`endif

endpackage

// File: rtl/ef_channel.sv
// One signed min/max tracker; exposes the shifted extrema that include the sample of this cycle.
// Under EXTREMUM_FINDER_P2P_EN it also produces the saturated, logically shifted peak-to-peak.
module ef_channel
    import vibrometer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_load,
    input  logic                          i_update,
    input  logic signed [SAMPLE_WIDTH-1:0] i_sample,
    input  logic [EF_LOG_SHIFT_W-1:0]     i_shift,
    output logic [SAMPLE_WIDTH-1:0]       o_field_max,
`ifdef EXTREMUM_FINDER_P2P_EN
    output logic [SAMPLE_WIDTH-1:0]       o_field_p2p,
`endif
    output logic [SAMPLE_WIDTH-1:0]       o_field_min
);

    localparam logic [EF_LOG_SHIFT_W-1:0] SW_SHIFT = EF_LOG_SHIFT_W'(SAMPLE_WIDTH);

    logic signed [SAMPLE_WIDTH-1:0] r_max;
    logic signed [SAMPLE_WIDTH-1:0] r_min;
    logic signed [SAMPLE_WIDTH-1:0] w_max_next;
    logic signed [SAMPLE_WIDTH-1:0] w_min_next;

    function automatic logic [SAMPLE_WIDTH-1:0] sra_field(
        input logic signed [SAMPLE_WIDTH-1:0] x,
        input logic [EF_LOG_SHIFT_W-1:0]      sh
    );
        if (sh >= SW_SHIFT) begin
            return {SAMPLE_WIDTH{x[SAMPLE_WIDTH-1]}};
        end
        return x >>> sh;
    endfunction

    always_comb begin
        w_max_next = r_max;
        w_min_next = r_min;
        if (i_load) begin
            w_max_next = i_sample;
            w_min_next = i_sample;
        end else if (i_update) begin
            if (i_sample > r_max) w_max_next = i_sample;
            if (i_sample < r_min) w_min_next = i_sample;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_max <= '0;
            r_min <= '0;
        end else if (i_load || i_update) begin
            r_max <= w_max_next;
            r_min <= w_min_next;
        end
    end

    assign o_field_max = sra_field(w_max_next, i_shift);
    assign o_field_min = sra_field(w_min_next, i_shift);

`ifdef EXTREMUM_FINDER_P2P_EN
    logic [SAMPLE_WIDTH:0] w_diff;
    logic [SAMPLE_WIDTH:0] w_diff_sh;

    // Sign-extend by one bit so max-min never wraps; the result is non-negative.
    assign w_diff      = {w_max_next[SAMPLE_WIDTH-1], w_max_next} - {w_min_next[SAMPLE_WIDTH-1], w_min_next};
    assign w_diff_sh   = w_diff >> i_shift;
    assign o_field_p2p = w_diff_sh[SAMPLE_WIDTH] ? {SAMPLE_WIDTH{1'b1}} : w_diff_sh[SAMPLE_WIDTH-1:0];
`endif

endmodule

// File: rtl/extremum_finder_mc.sv
// Multi-channel windowed min/max detector: window counter, per-window config latch and output beat register.
// Build option EXTREMUM_FINDER_P2P_EN widens each channel to {p2p,max,min}.
module extremum_finder_mc
    import vibrometer_pkg::*;
#(
    parameter int CHANNELS      = 2,
    parameter int SAMPLE_WIDTH  = 16,
    parameter int MAX_LOG_COUNT = 24
) (
    input  logic                                         SYS_aclk,
    input  logic                                         SYS_aresetn,
    input  logic [EF_LOG_COUNT_W-1:0]                    EF_log_count,
    input  logic [EF_LOG_SHIFT_W-1:0]                    EF_log_shift,
    input  logic [CHANNELS*SAMPLE_WIDTH-1:0]             S_AXIS_tdata,
    input  logic                                         S_AXIS_tvalid,
    output logic                                         S_AXIS_tready,
    output logic [CHANNELS*OUT_FIELDS*SAMPLE_WIDTH-1:0]  M_AXIS_tdata,
    output logic                                         M_AXIS_tvalid,
    input  logic                                         M_AXIS_tready,
    output logic                                         EF_overrun
);

    localparam int CW = MAX_LOG_COUNT + 1;
    localparam int OW = CHANNELS * OUT_FIELDS * SAMPLE_WIDTH;
    localparam logic [EF_LOG_COUNT_W-1:0] MAX_LC = EF_LOG_COUNT_W'(MAX_LOG_COUNT);

    logic [CW-1:0]             r_count;
    logic [EF_LOG_COUNT_W-1:0] r_log_count;
    logic [EF_LOG_SHIFT_W-1:0] r_log_shift;

    logic                      w_accept;
    logic                      w_first;
    logic                      w_done;
    logic [EF_LOG_COUNT_W-1:0] w_log_count;
    logic [EF_LOG_SHIFT_W-1:0] w_log_shift;
    logic [CW-1:0]             w_count_inc;
    logic [CW-1:0]             w_target;
    logic [OW-1:0]             w_result;

    assign S_AXIS_tready = 1'b1;
    assign w_accept      = S_AXIS_tvalid;
    assign w_first       = (r_count == '0);

    // The first accept of a window uses the live config so a 1-sample window (N=0) still works.
    assign w_log_count = w_first ? ((EF_log_count > MAX_LC) ? MAX_LC : EF_log_count) : r_log_count;
    assign w_log_shift = w_first ? EF_log_shift : r_log_shift;
    assign w_count_inc = w_first ? CW'(1) : (r_count + CW'(1));
    assign w_target    = CW'(1) << w_log_count;
    assign w_done      = w_accept && (w_count_inc == w_target);

    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            r_count     <= '0;
            r_log_count <= '0;
            r_log_shift <= '0;
        end else if (w_accept) begin
            r_count <= w_done ? '0 : w_count_inc;
            if (w_first) begin
                r_log_count <= w_log_count;
                r_log_shift <= EF_log_shift;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        ef_channel #(
            .SAMPLE_WIDTH (SAMPLE_WIDTH)
        ) u_ch (
            .i_clk       (SYS_aclk),
            .i_rst_n     (SYS_aresetn),
            .i_load      (w_accept && w_first),
            .i_update    (w_accept && !w_first),
            .i_sample    (S_AXIS_tdata[c*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
            .i_shift     (w_log_shift),
            .o_field_max (w_result[(c*OUT_FIELDS+FIELD_MAX)*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
`ifdef EXTREMUM_FINDER_P2P_EN
            .o_field_p2p (w_result[(c*OUT_FIELDS+FIELD_P2P)*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
`endif
            .o_field_min (w_result[(c*OUT_FIELDS+FIELD_MIN)*SAMPLE_WIDTH +: SAMPLE_WIDTH])
        );
    end

    // Output beat: valid/ready handshake; tdata changes only when empty, accepted, or overwritten by a new result.
    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            M_AXIS_tdata  <= '0;
            M_AXIS_tvalid <= 1'b0;
            EF_overrun    <= 1'b0;
        end else begin
            EF_overrun <= w_done && M_AXIS_tvalid && !M_AXIS_tready;
            if (w_done) begin
                M_AXIS_tdata  <= w_result;
                M_AXIS_tvalid <= 1'b1;
            end else if (M_AXIS_tvalid && M_AXIS_tready) begin
                M_AXIS_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_extremum_finder_mc.sv
// Directed self-checking bench for extremum_finder_mc (CHANNELS=2, SAMPLE_WIDTH=16).
// The p2p scenario runs only when EXTREMUM_FINDER_P2P_EN is defined.
module tb_extremum_finder_mc;
    import vibrometer_pkg::*;

    localparam int CH = 2;
    localparam int SW = 16;
    localparam int OW = CH * OUT_FIELDS * SW;

    logic          clk;
    logic          rst_n;
    logic [4:0]    log_count;
    logic [5:0]    log_shift;
    logic [CH*SW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [OW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    extremum_finder_mc #(
        .CHANNELS      (CH),
        .SAMPLE_WIDTH  (SW),
        .MAX_LOG_COUNT (24)
    ) dut (
        .SYS_aclk      (clk),
        .SYS_aresetn   (rst_n),
        .EF_log_count  (log_count),
        .EF_log_shift  (log_shift),
        .S_AXIS_tdata  (s_tdata),
        .S_AXIS_tvalid (s_tvalid),
        .S_AXIS_tready (s_tready),
        .M_AXIS_tdata  (m_tdata),
        .M_AXIS_tvalid (m_tvalid),
        .M_AXIS_tready (m_tready),
        .EF_overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SW-1:0] fld(input int ch, input int idx);
        return m_tdata[(ch*OUT_FIELDS+idx)*SW +: SW];
    endfunction

    // One accepted sample per call; outputs are sampled 1 ns after the edge.
    task automatic drive(input logic [SW-1:0] a, input logic [SW-1:0] b);
        s_tdata  = {b, a};
        s_tvalid = 1'b1;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid got %0b want 0", m_tvalid); end
        checks++; if (m_tdata !== '0) begin errors++; $display("FAIL rst_tdata got %h want 0", m_tdata); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %0b want 0", overrun); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL s_tready got %0b want 1", s_tready); end
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL post_rst_tvalid got %0b want 0", m_tvalid); end
    endtask

    task automatic test_window8();
        logic [SW-1:0] s0 [8] = '{16'(-20), 16'(-10), 16'd10, 16'd20, 16'd10, 16'(-10), 16'(-30), 16'(-20)};
        log_count = 5'd3;
        log_shift = 6'd1;
        for (int i = 0; i < 8; i++) begin
            drive(s0[i], 16'(i));
            if (i == 6) begin
                checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL w8_early got %0b want 0", m_tvalid); end
            end
        end
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL w8_valid got %0b want 1", m_tvalid); end
        checks++; if (fld(0, FIELD_MAX) !== 16'd10) begin errors++; $display("FAIL w8_ch0_max got %h want 000a", fld(0, FIELD_MAX)); end
        checks++; if (fld(0, FIELD_MIN) !== 16'hfff1) begin errors++; $display("FAIL w8_ch0_min got %h want fff1", fld(0, FIELD_MIN)); end
        checks++; if (fld(1, FIELD_MAX) !== 16'd3) begin errors++; $display("FAIL w8_ch1_max got %h want 0003", fld(1, FIELD_MAX)); end
        checks++; if (fld(1, FIELD_MIN) !== 16'd0) begin errors++; $display("FAIL w8_ch1_min got %h want 0000", fld(1, FIELD_MIN)); end
        idle();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL w8_drop got %0b want 0", m_tvalid); end
    endtask

    task automatic test_back_to_back();
        log_count = 5'd0;
        log_shift = 6'd0;
        drive(16'd5, 16'd0);
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL n0_valid1 got %0b want 1", m_tvalid); end
        checks++; if (fld(0, FIELD_MAX) !== 16'd5 || fld(0, FIELD_MIN) !== 16'd5) begin errors++; $display("FAIL n0_beat1 got %h/%h want 0005/0005", fld(0, FIELD_MAX), fld(0, FIELD_MIN)); end
        drive(16'(-7), 16'd0);
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL n0_valid2 got %0b want 1", m_tvalid); end
        checks++; if (fld(0, FIELD_MAX) !== 16'hfff9 || fld(0, FIELD_MIN) !== 16'hfff9) begin errors++; $display("FAIL n0_beat2 got %h/%h want fff9/fff9", fld(0, FIELD_MAX), fld(0, FIELD_MIN)); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL n0_overrun got %0b want 0", overrun); end
        idle();
    endtask

    task automatic test_overrun();
        logic [SW-1:0] w2 [4] = '{16'd8, 16'(-3), 16'd6, 16'd5};
        log_count = 5'd2;
        log_shift = 6'd0;
        m_tready  = 1'b0;
        for (int i = 1; i <= 4; i++) drive(16'(i), 16'd0);
        checks++; if (m_tvalid !== 1'b1 || fld(0, FIELD_MAX) !== 16'd4 || fld(0, FIELD_MIN) !== 16'd1) begin errors++; $display("FAIL ov_beat1 got v=%0b %h/%h want 1 0004/0001", m_tvalid, fld(0, FIELD_MAX), fld(0, FIELD_MIN)); end
        for (int i = 0; i < 3; i++) begin
            drive(w2[i], 16'd0);
            checks++; if (m_tvalid !== 1'b1 || fld(0, FIELD_MAX) !== 16'd4 || fld(0, FIELD_MIN) !== 16'd1 || overrun !== 1'b0) begin errors++; $display("FAIL ov_hold got v=%0b %h/%h o=%0b want 1 0004/0001 0", m_tvalid, fld(0, FIELD_MAX), fld(0, FIELD_MIN), overrun); end
        end
        drive(w2[3], 16'd0);
        checks++; if (m_tvalid !== 1'b1 || fld(0, FIELD_MAX) !== 16'd8 || fld(0, FIELD_MIN) !== 16'hfffd) begin errors++; $display("FAIL ov_beat2 got v=%0b %h/%h want 1 0008/fffd", m_tvalid, fld(0, FIELD_MAX), fld(0, FIELD_MIN)); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ov_pulse got %0b want 1", overrun); end
        idle();
        checks++; if (overrun !== 1'b0 || m_tvalid !== 1'b1) begin errors++; $display("FAIL ov_after got o=%0b v=%0b want 0 1", overrun, m_tvalid); end
        m_tready = 1'b1;
        idle();
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL ov_accept got %0b want 0", m_tvalid); end
    endtask

    task automatic test_cfg_change();
        logic [SW-1:0] w2 [4] = '{16'd10, 16'(-5), 16'd3, 16'd2};
        log_count = 5'd3;
        log_shift = 6'd0;
        for (int i = 1; i <= 3; i++) drive(16'(i), 16'd0);
        log_count = 5'd2;
        drive(16'd4, 16'd0);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL cfg_mid got %0b want 0", m_tvalid); end
        for (int i = 5; i <= 8; i++) drive(16'(i), 16'd0);
        checks++; if (m_tvalid !== 1'b1 || fld(0, FIELD_MAX) !== 16'd8 || fld(0, FIELD_MIN) !== 16'd1) begin errors++; $display("FAIL cfg_win8 got v=%0b %h/%h want 1 0008/0001", m_tvalid, fld(0, FIELD_MAX), fld(0, FIELD_MIN)); end
        for (int i = 0; i < 3; i++) drive(w2[i], 16'd0);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL cfg_win4_early got %0b want 0", m_tvalid); end
        drive(w2[3], 16'd0);
        checks++; if (m_tvalid !== 1'b1 || fld(0, FIELD_MAX) !== 16'd10 || fld(0, FIELD_MIN) !== 16'hfffb) begin errors++; $display("FAIL cfg_win4 got v=%0b %h/%h want 1 000a/fffb", m_tvalid, fld(0, FIELD_MAX), fld(0, FIELD_MIN)); end
        idle();
    endtask

    task automatic test_shift_and_reset();
        log_count = 5'd1;
        log_shift = 6'd20;
        m_tready  = 1'b0;
        drive(16'd100, 16'(-100));
        drive(16'(-100), 16'd100);
        checks++; if (fld(0, FIELD_MAX) !== 16'd0 || fld(0, FIELD_MIN) !== 16'hffff) begin errors++; $display("FAIL sh_ch0 got %h/%h want 0000/ffff", fld(0, FIELD_MAX), fld(0, FIELD_MIN)); end
        checks++; if (fld(1, FIELD_MAX) !== 16'd0 || fld(1, FIELD_MIN) !== 16'hffff) begin errors++; $display("FAIL sh_ch1 got %h/%h want 0000/ffff", fld(1, FIELD_MAX), fld(1, FIELD_MIN)); end
        log_count = 5'd2;
        log_shift = 6'd0;
        drive(16'd7, 16'd7);
        drive(16'd7, 16'd7);
        rst_n = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0 || m_tdata !== '0) begin errors++; $display("FAIL rst_mid got v=%0b d=%h want 0 0", m_tvalid, m_tdata); end
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        m_tready = 1'b1;
        idle();
        drive(16'd9, 16'd9);
        drive(16'd9, 16'd9);
        checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_partial got %0b want 0", m_tvalid); end
        drive(16'd9, 16'd9);
        drive(16'd9, 16'd9);
        checks++; if (m_tvalid !== 1'b1 || fld(0, FIELD_MAX) !== 16'd9 || fld(0, FIELD_MIN) !== 16'd9) begin errors++; $display("FAIL rst_fresh got v=%0b %h/%h want 1 0009/0009", m_tvalid, fld(0, FIELD_MAX), fld(0, FIELD_MIN)); end
        idle();
    endtask

`ifdef EXTREMUM_FINDER_P2P_EN
    task automatic test_p2p();
        log_count = 5'd1;
        log_shift = 6'd0;
        drive(16'd0, 16'd32767);
        drive(16'd0, 16'h8000);
        checks++; if (fld(1, FIELD_P2P) !== 16'hffff) begin errors++; $display("FAIL p2p_sh0 got %h want ffff", fld(1, FIELD_P2P)); end
        checks++; if (fld(1, FIELD_MAX) !== 16'h7fff || fld(1, FIELD_MIN) !== 16'h8000) begin errors++; $display("FAIL p2p_ext0 got %h/%h want 7fff/8000", fld(1, FIELD_MAX), fld(1, FIELD_MIN)); end
        log_shift = 6'd1;
        drive(16'd0, 16'd32767);
        drive(16'd0, 16'h8000);
        checks++; if (fld(1, FIELD_P2P) !== 16'h7fff) begin errors++; $display("FAIL p2p_sh1 got %h want 7fff", fld(1, FIELD_P2P)); end
        checks++; if (fld(1, FIELD_MAX) !== 16'h3fff || fld(1, FIELD_MIN) !== 16'hc000) begin errors++; $display("FAIL p2p_ext1 got %h/%h want 3fff/c000", fld(1, FIELD_MAX), fld(1, FIELD_MIN)); end
        idle();
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        log_count = 5'd0;
        log_shift = 6'd0;
        s_tdata   = '0;
        s_tvalid  = 1'b0;
        m_tready  = 1'b1;
        test_reset();
        test_window8();
        test_back_to_back();
        test_overrun();
        test_cfg_change();
        test_shift_and_reset();
`ifdef EXTREMUM_FINDER_P2P_EN
        test_p2p();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
